debug_loader: RTL
=================

DEBUG_LOADER -- requirements
Module: debug_loader

Interface
REQ-001 Parameter ADDR_W, 10, instruction-memory word-address width.
REQ-002 Parameter HALT_WORD, 32'hFFFF_FFFF, program terminator word.
REQ-003 Clock  in  1  single clock; all state updates on the rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 RxData  in  8  byte from UART receiver.
REQ-006 RxValid  in  1  one-cycle strobe; RxData valid.
REQ-007 TxBusy  in  1  UART transmitter busy.
REQ-008 TxData  out  8  byte to transmit.
REQ-009 TxStart  out  1  one-cycle transmit request.
REQ-010 HaltDetected  in  1  pipeline has retired HALT_WORD.
REQ-011 PCResult  in  32  current pipeline PC.
REQ-012 ImemWrEn  out  1  instruction-memory write strobe.
REQ-013 ImemAddr  out  ADDR_W  instruction-memory word address.
REQ-014 ImemWrData  out  32  instruction-memory write word.
REQ-015 CpuEnable  out  1  pipeline clock enable.
REQ-016 CpuReset  out  1  pipeline synchronous reset.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, WRITE, RUN, STEP, SEND_PC.
- IDLE: on RxValid, 0x4C goes to LOAD; 0x52 goes to RUN; 0x53 goes to STEP; any other byte is ignored.
REQ-018 LOAD SHALL assemble 4 received bytes LSB-first into one word, then enter WRITE.
REQ-019 WRITE SHALL assert ImemWrEn for exactly one cycle with the assembled word at ImemAddr, then increment ImemAddr.
- If the word equals HALT_WORD, WRITE returns to IDLE; otherwise it returns to LOAD.
REQ-020 ImemAddr SHALL wrap from 2^ADDR_W-1 to 0 with no error, and loading SHALL continue.
REQ-021 CpuReset SHALL be high while in LOAD or WRITE and low in all other states.
- Entering LOAD clears ImemAddr and the byte counter.
REQ-022 In RUN, CpuEnable SHALL be high.
- RUN exits to SEND_PC when HaltDetected=1, or on RxValid with 0x48.
- If both occur in the same cycle, the exit is taken once, to SEND_PC.
REQ-023 STEP SHALL assert CpuEnable for exactly one cycle, then enter SEND_PC.
REQ-024 SEND_PC SHALL latch PCResult on entry and transmit its 4 bytes LSB-first, then return to IDLE.
REQ-025 TxStart SHALL pulse for one cycle only when TxBusy=0.
- The next byte waits for TxBusy to rise and then fall, or for one cycle after TxStart if TxBusy stays low.
REQ-026 RxValid bytes received in STEP and SEND_PC SHALL be dropped; in RUN only 0x48 has effect.
REQ-027 CpuEnable SHALL be low in all states except RUN and the single STEP cycle.
REQ-028 ImemWrEn and TxStart SHALL never be high in the same cycle.

Reset
REQ-029 On Reset=1 the block SHALL enter IDLE and apply these output values:
- ImemAddr=0, ImemWrData=0, ImemWrEn=0.
- TxData=0, TxStart=0.
- CpuEnable=0, CpuReset=1 for that cycle.
- Byte counter cleared.
REQ-030 A Reset in any state, including mid-word in LOAD or mid-transmit in SEND_PC, SHALL abandon the operation, and the partial word or bytes SHALL be discarded.
REQ-031 After Reset, CpuReset SHALL remain high until the first cycle in IDLE completes.

Structure
REQ-032 A shared package SHALL hold:
- the state enumeration;
- the command constants 0x4C, 0x52, 0x53, 0x48;
- HALT_WORD's default.
REQ-033 The byte-to-word assembler and the word-to-byte serializer SHALL share one 2-bit byte counter.
REQ-034 One sub-module, tx_serializer (32-bit to 4-byte transmit with TxBusy handshake), is natural.
- Everything else is inline.

Verification
REQ-035 Load scenario.
- Stimulus: 0x4C, then bytes 78 56 34 12, then FF FF FF FF.
- Required: writes 0x12345678 at addr 0 and 0xFFFFFFFF at addr 1, returns to IDLE, and CpuReset is high throughout.
REQ-036 Step scenario.
- Stimulus: 0x53 with PCResult=0x00000010.
- Required: exactly one CpuEnable cycle, then TxData 10,00,00,00 sent in order, each with TxStart only while TxBusy=0.
REQ-037 Run scenario.
- Stimulus: 0x52, then HaltDetected raised after 20 cycles.
- Required: CpuEnable high for 20 cycles, then low, and the latched PC is transmitted.
- Repeat with 0x48 and HaltDetected arriving in the same cycle: a single SEND_PC results.
REQ-038 Wrap scenario.
- Stimulus: ADDR_W=2, load 5 words.
- Required: the 5th write goes to addr 0.
REQ-039 Reset scenario.
- Stimulus: Reset after 2 bytes of a word in LOAD.
- Required: no ImemWrEn pulse; a subsequent load writes starting at addr 0 with the correct word.

Source files
------------

// File: rtl/debug_loader_pkg.sv
// Shared definitions for the UART debug loader: FSM states, command bytes and defaults.
package debug_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WRITE,
      ST_RUN,
      ST_STEP,
      ST_SEND_PC
   } state_e;

   typedef enum logic [1:0] {
      TX_ISSUE,
      TX_PULSE,
      TX_SETTLE,
      TX_BUSY
   } tx_state_e;

   localparam logic [7:0]  CMD_LOAD          = 8'h4C;
   localparam logic [7:0]  CMD_RUN           = 8'h52;
   localparam logic [7:0]  CMD_STEP          = 8'h53;
   localparam logic [7:0]  CMD_HALT          = 8'h48;
   localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

   function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
      return w[8*idx +: 8];
   endfunction

endpackage

// File: rtl/debug_loader_tx_serializer.sv
// Sends one byte of a 32-bit word per handshake; the owner advances byte_idx on byte_done.
module tx_serializer
   import debug_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        active,
   input  logic [31:0] word,
   input  logic [1:0]  byte_idx,
   input  logic        tx_busy,
   output logic [7:0]  tx_data,
   output logic        tx_start,
   output logic        byte_done
);

   tx_state_e  st_q, st_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic       tx_start_q, tx_start_d;

   always_comb begin
      st_d       = st_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      byte_done  = 1'b0;
      if (!active) begin
         st_d = TX_ISSUE;
      end else begin
         case (st_q)
            TX_ISSUE: begin
               if (!tx_busy) begin
                  tx_start_d = 1'b1;
                  tx_data_d  = word_byte(word, byte_idx);
                  st_d       = TX_PULSE;
               end
            end
            TX_PULSE: st_d = TX_SETTLE;
            // Transmitter gets one cycle to raise busy; if it never does the byte is done.
            TX_SETTLE: begin
               if (tx_busy) begin
                  st_d = TX_BUSY;
               end else begin
                  byte_done = 1'b1;
                  st_d      = TX_ISSUE;
               end
            end
            TX_BUSY: begin
               if (!tx_busy) begin
                  byte_done = 1'b1;
                  st_d      = TX_ISSUE;
               end
            end
            default: st_d = TX_ISSUE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q       <= TX_ISSUE;
         tx_data_q  <= 8'h00;
         tx_start_q <= 1'b0;
      end else begin
         st_q       <= st_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
      end
   end

   assign tx_data  = tx_data_q;
   assign tx_start = tx_start_q;

endmodule

// File: rtl/debug_loader.sv
// UART-driven debug controller: loads instruction memory, runs/steps the pipeline, reports PC.
module debug_loader
   import debug_loader_pkg::*;
#(
   parameter int          ADDR_W    = 10,
   parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic [7:0]        RxData,
   input  logic              RxValid,
   input  logic              TxBusy,
   output logic [7:0]        TxData,
   output logic              TxStart,
   input  logic              HaltDetected,
   input  logic [31:0]       PCResult,
   output logic              ImemWrEn,
   output logic [ADDR_W-1:0] ImemAddr,
   output logic [31:0]       ImemWrData,
   output logic              CpuEnable,
   output logic              CpuReset
);

   state_e            state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [31:0]       word_q, word_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wr_en_q, wr_en_d;
   logic [31:0]       wr_data_q, wr_data_d;
   logic              cpu_en_q, cpu_en_d;
   logic              cpu_rst_q, cpu_rst_d;
   logic [31:0]       pc_q, pc_d;
   logic              tx_active;
   logic              byte_done;

   assign tx_active = (state_q == ST_SEND_PC);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      word_d    = word_q;
      addr_d    = addr_q;
      wr_en_d   = 1'b0;
      wr_data_d = wr_data_q;
      pc_d      = pc_q;
      case (state_q)
         ST_IDLE: begin
            if (RxValid) begin
               case (RxData)
                  CMD_LOAD: begin
                     state_d = ST_LOAD;
                     addr_d  = '0;
                     cnt_d   = 2'd0;
                  end
                  CMD_RUN:  state_d = ST_RUN;
                  CMD_STEP: state_d = ST_STEP;
                  default:  state_d = ST_IDLE;
               endcase
            end
         end
         ST_LOAD: begin
            if (RxValid) begin
               word_d[8*cnt_q +: 8] = RxData;
               cnt_d                = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_d   = ST_WRITE;
                  wr_en_d   = 1'b1;
                  wr_data_d = word_d;
               end
            end
         end
         // Address advances after the write cycle; natural overflow gives the wrap.
         ST_WRITE: begin
            addr_d  = addr_q + 1'b1;
            state_d = (wr_data_q == HALT_WORD) ? ST_IDLE : ST_LOAD;
         end
         ST_RUN: begin
            if (HaltDetected || (RxValid && RxData == CMD_HALT)) begin
               state_d = ST_SEND_PC;
               pc_d    = PCResult;
               cnt_d   = 2'd0;
            end
         end
         ST_STEP: begin
            state_d = ST_SEND_PC;
            pc_d    = PCResult;
            cnt_d   = 2'd0;
         end
         ST_SEND_PC: begin
            if (byte_done) begin
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      cpu_en_d  = (state_d == ST_RUN) || (state_d == ST_STEP);
      cpu_rst_d = (state_d == ST_LOAD) || (state_d == ST_WRITE);
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 2'd0;
         word_q    <= 32'h0;
         addr_q    <= '0;
         wr_en_q   <= 1'b0;
         wr_data_q <= 32'h0;
         cpu_en_q  <= 1'b0;
         cpu_rst_q <= 1'b1;
         pc_q      <= 32'h0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         word_q    <= word_d;
         addr_q    <= addr_d;
         wr_en_q   <= wr_en_d;
         wr_data_q <= wr_data_d;
         cpu_en_q  <= cpu_en_d;
         cpu_rst_q <= cpu_rst_d;
         pc_q      <= pc_d;
      end
   end

   tx_serializer u_tx (
      .clk       (Clock),
      .rst       (Reset),
      .active    (tx_active),
      .word      (pc_q),
      .byte_idx  (cnt_q),
      .tx_busy   (TxBusy),
      .tx_data   (TxData),
      .tx_start  (TxStart),
      .byte_done (byte_done)
   );

   assign ImemWrEn   = wr_en_q;
   assign ImemAddr   = addr_q;
   assign ImemWrData = wr_data_q;
   assign CpuEnable  = cpu_en_q;
   assign CpuReset   = cpu_rst_q;

endmodule
